// File: rtl/sm_color_pkg.sv
// Shared definitions for the colour event reporter: colour codes, ASCII
// message characters, the queued event entry and the message byte lookup.
package sm_color_pkg;

  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_BLUE  = 2'b10;
  localparam logic [1:0] COL_GREEN = 2'b11;

  localparam logic [7:0] ASC_C    = 8'h43;
  localparam logic [7:0] ASC_R    = 8'h52;
  localparam logic [7:0] ASC_G    = 8'h47;
  localparam logic [7:0] ASC_B    = 8'h42;
  localparam logic [7:0] ASC_HASH = 8'h23;
  localparam logic [7:0] ASC_0    = 8'h30;

  typedef struct packed {
    logic [1:0] si;
    logic [1:0] color;
  } evt_t;

  // Byte idx of the 4-byte message "C<colour><si>#" for one event.
  function automatic logic [7:0] msg_byte(evt_t e, logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0: b = ASC_C;
      2'd1: begin
        case (e.color)
          COL_RED:  b = ASC_R;
          COL_BLUE: b = ASC_B;
          default:  b = ASC_G;  // COL_NONE is never queued
        endcase
      end
      2'd2:    b = ASC_0 + {6'b0, e.si};
      default: b = ASC_HASH;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sm_uart_tx_byte.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, optional
// even parity bit, stop bit. Each bit lasts CLKS_PER_BIT clocks.
// Optional feature macro: SM_COLOR_REPORT_PARITY_EN (8E1 instead of 8N1).
module sm_uart_tx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_t;

  st_t           st, st_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
`ifdef SM_COLOR_REPORT_PARITY_EN
  logic          par;
`endif

  assign tick = (cnt == LAST);
  assign busy = (st != S_IDLE);
  assign done = (st == S_STOP) && tick;

  // Bit sequencing: leave each non-idle state after one full bit period.
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:  if (start) st_nx = S_START;
      S_START: if (tick) st_nx = S_DATA;
`ifdef SM_COLOR_REPORT_PARITY_EN
      S_DATA:  if (tick && bit_idx == 3'd7) st_nx = S_PAR;
      S_PAR:   if (tick) st_nx = S_STOP;
`else
      S_DATA:  if (tick && bit_idx == 3'd7) st_nx = S_STOP;
`endif
      S_STOP:  if (tick) st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  // Line level decoded from state; reset forces idle-high at once.
  always_comb begin
    tx = 1'b1;
    case (st)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[0];
`ifdef SM_COLOR_REPORT_PARITY_EN
      S_PAR:   tx = par;
`endif
      default: tx = 1'b1;
    endcase
  end

  // Bit timer, data shifter and byte latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef SM_COLOR_REPORT_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      st <= st_nx;
      if (st == S_IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
        if (start) begin
          shreg <= data;
`ifdef SM_COLOR_REPORT_PARITY_EN
          par   <= ^data;
`endif
        end
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (st == S_DATA && tick) begin
          bit_idx <= bit_idx + 3'd1;
          shreg   <= {1'b0, shreg[7:1]};
        end
      end
    end
  end

endmodule

// File: rtl/sm_color_event_reporter.sv
// Colour event reporter: debounces the detector colour code, drives the RGB
// LEDs, queues {si, colour} events on each new non-black detection at an SI
// node and sends each as "C<R|B|G><1..3>#" over UART.
// Optional feature macro: SM_COLOR_REPORT_PARITY_EN (even parity, 8E1).
module sm_color_event_reporter
  import sm_color_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 5208,
  parameter int STABLE_CYCLES = 1024,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    color,
  input  logic [1:0]                    si,
  output logic                          tx,
  output logic                          led_r,
  output logic                          led_g,
  output logic                          led_b,
  output logic                          event_drop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STABLE = SW'(STABLE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_SEND, R_NEXT} rep_st_t;

  // ---------------- stability filter ----------------
  logic [1:0]    samp, acc;
  logic [SW-1:0] stab_cnt, stab_nx;
  logic          accept, push;

  // Run length of the incoming code (saturating) and the accept/push decision.
  always_comb begin
    if (color == samp)
      stab_nx = (stab_cnt == STABLE) ? stab_cnt : stab_cnt + 1'b1;
    else
      stab_nx = SW'(1);
    accept = (si != 2'b00) && (stab_nx == STABLE) && (color != acc);
    push   = accept && (color != COL_NONE);
  end

  // Sample register, run counter and accepted colour; no SI holds it black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp     <= COL_NONE;
      acc      <= COL_NONE;
      stab_cnt <= '0;
    end else begin
      samp <= color;
      if (si == 2'b00) begin
        acc      <= COL_NONE;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_nx;
        if (accept) acc <= color;
      end
    end
  end

  assign led_r = (acc == COL_RED);
  assign led_g = (acc == COL_GREEN);
  assign led_b = (acc == COL_BLUE);

  // ---------------- event FIFO ----------------
  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, push_ok, drop_q;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop);

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{si: si, color: color};
  end

  // Pointers, occupancy and the drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= push && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_level = count;
  assign event_drop = drop_q;

  // ---------------- message sequencer ----------------
  rep_st_t    r_st, r_nx;
  evt_t       cur;
  logic [1:0] byte_idx;
  logic       tx_start, tx_busy, tx_done;
  logic [7:0] tx_data;

  // Pop and start byte 0 together ('C' does not depend on the entry);
  // later bytes are started from the NEXT cycle using the latched entry.
  always_comb begin
    r_nx     = r_st;
    pop      = 1'b0;
    tx_start = 1'b0;
    tx_data  = ASC_C;
    case (r_st)
      R_IDLE: if (!empty && !tx_busy) begin
        pop      = 1'b1;
        tx_start = 1'b1;
        r_nx     = R_SEND;
      end
      R_SEND: if (tx_done) r_nx = R_NEXT;
      R_NEXT: if (byte_idx != 2'd3) begin
        tx_start = 1'b1;
        tx_data  = msg_byte(cur, byte_idx + 2'd1);
        r_nx     = R_SEND;
      end else begin
        r_nx = R_IDLE;
      end
      default: r_nx = R_IDLE;
    endcase
  end

  // Sequencer state, latched entry and byte index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= R_IDLE;
      cur      <= '0;
      byte_idx <= '0;
    end else begin
      r_st <= r_nx;
      if (pop) begin
        cur      <= mem[rd_ptr];
        byte_idx <= '0;
      end else if (r_st == R_NEXT && byte_idx != 2'd3) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  sm_uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (tx_data),
    .tx    (tx),
    .busy  (tx_busy),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_sm_color_event_reporter.sv
// Bench for sm_color_event_reporter (CLKS_PER_BIT=4, STABLE_CYCLES=4,
// FIFO_DEPTH=4). Stimulus pushes hand-computed expected message bytes into a
// queue; a UART monitor decodes tx and compares each received byte.
// Honours SM_COLOR_REPORT_PARITY_EN (expects 8E1 framing when defined).
module tb_sm_color_event_reporter;

  localparam int BIT = 4;
`ifdef SM_COLOR_REPORT_PARITY_EN
  localparam int STOP_AT = 10 * BIT;
`else
  localparam int STOP_AT = 9 * BIT;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] color, si;
  logic       tx, led_r, led_g, led_b, event_drop;
  logic [2:0] fifo_level;
  logic [2:0] leds;

  int checks = 0;
  int errs   = 0;
  logic [7:0] exp_q[$];

  int   drop_cnt = 0;
  bit   m_busy = 1'b0;
  int   m_cnt;
  logic [7:0] m_byte;

  assign leds = {led_r, led_g, led_b};

  always #5 clk = ~clk;

  sm_color_event_reporter #(
    .CLKS_PER_BIT(4), .STABLE_CYCLES(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .color(color), .si(si), .tx(tx),
    .led_r(led_r), .led_g(led_g), .led_b(led_b),
    .event_drop(event_drop), .fifo_level(fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_msg(input logic [7:0] b0, b1, b2, b3);
    exp_q.push_back(b0); exp_q.push_back(b1);
    exp_q.push_back(b2); exp_q.push_back(b3);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0 && !m_busy) begin ok = 1'b1; break; end
      step(1);
    end
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: timeout with %0d bytes outstanding, expected 0", name, exp_q.size());
    end
    step(4);
  endtask

  // UART monitor: samples tx mid-cycle, one sample per bit period.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (event_drop === 1'b1) drop_cnt++;
      if (rst) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (tx === 1'b0) begin m_busy = 1'b1; m_cnt = 0; m_byte = '0; end
      end else begin
        m_cnt++;
        if (m_cnt % BIT == 0 && m_cnt <= 8 * BIT) m_byte[m_cnt/BIT - 1] = tx;
`ifdef SM_COLOR_REPORT_PARITY_EN
        if (m_cnt == 9 * BIT) chk("parity_bit", tx, ^m_byte);
`endif
        if (m_cnt == STOP_AT) begin
          chk("stop_bit", tx, 1'b1);
          checks++;
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL rx_byte: got %0h expected no byte", m_byte);
          end else begin
            e = exp_q.pop_front();
            if (m_byte !== e) begin
              errs++;
              $display("FAIL rx_byte: got %0h expected %0h", m_byte, e);
            end
          end
          m_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1);
  end

  initial begin : stim
    int bad;
    int d0;
    int ev_si  [6] = '{1, 1, 2, 3, 1, 2};
    int ev_col [6] = '{1, 2, 3, 1, 3, 2};

    rst = 1'b1; color = 2'b00; si = 2'd2;
    step(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_leds", leds, 3'b000);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_drop", event_drop, 1'b0);
    rst = 1'b0;

    // 1: red at SI 2 -> "CR2#"
    exp_msg(8'h43, 8'h52, 8'h32, 8'h23);
    color = 2'b01;
    step(3);
    chk("t1_led_pre", leds, 3'b000);
    step(1);
    chk("t1_led_r", leds, 3'b100);
    chk("t1_level_push", fifo_level, 3'd1);
    step(1);
    chk("t1_level_pop", fifo_level, 3'd0);
    wait_drain("t1_drain", 400);

    // 2: unstable colour never accepted
    color = 2'b00;
    step(6);
    bad = 0;
    for (int k = 0; k < 34; k++) begin
      color = (k % 2) ? 2'b11 : 2'b01;
      repeat (3) begin
        @(negedge clk);
        if (leds !== 3'b000 || fifo_level !== 3'd0 || tx !== 1'b1) bad++;
        step(1);
      end
    end
    chk("t2_quiet", bad, 0);

    // 3: no SI blocks reporting, then SI 3 -> "CG3#"
    si = 2'd0; color = 2'b11;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (leds !== 3'b000 || fifo_level !== 3'd0) bad++;
      step(1);
    end
    chk("t3_si0_quiet", bad, 0);
    exp_msg(8'h43, 8'h47, 8'h33, 8'h23);
    si = 2'd3;
    step(3);
    chk("t3_led_pre", leds, 3'b000);
    step(1);
    chk("t3_led_g", leds, 3'b010);
    wait_drain("t3_drain", 400);

    // 4: six events during one message; queue fills, fifth queued one drops
    si = 2'd1; color = 2'b00;
    step(6);
    exp_msg(8'h43, 8'h52, 8'h31, 8'h23);
    exp_msg(8'h43, 8'h42, 8'h31, 8'h23);
    exp_msg(8'h43, 8'h47, 8'h32, 8'h23);
    exp_msg(8'h43, 8'h52, 8'h33, 8'h23);
    exp_msg(8'h43, 8'h47, 8'h31, 8'h23);
    d0 = drop_cnt;
    for (int i = 0; i < 6; i++) begin
      si = ev_si[i][1:0];
      color = ev_col[i][1:0];
      step(5);
      if (i == 4) begin
        chk("t4_level_full", fifo_level, 3'd4);
        chk("t4_no_drop_yet", drop_cnt - d0, 0);
      end
      color = 2'b00;
      step(5);
    end
    chk("t4_level_sat", fifo_level, 3'd4);
    chk("t4_drop_once", drop_cnt - d0, 1);
    wait_drain("t4_drain", 1500);
    chk("t4_level_empty", fifo_level, 3'd0);

    // 5: reset during byte 1 of a message with a second event queued
    si = 2'd2;
    exp_q.push_back(8'h43);
    color = 2'b01; step(5);
    color = 2'b00; step(5);
    color = 2'b10; step(5);
    chk("t5_level_queued", fifo_level, 3'd1);
    step(45);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", tx, 1'b1);
    chk("t5_rst_level", fifo_level, 3'd0);
    chk("t5_rst_leds", leds, 3'b000);
    step(2);
    color = 2'b00;
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
      step(1);
    end
    chk("t5_idle_after_rst", bad, 0);
    chk("t5_queue_done", exp_q.size(), 0);

    // 6: blue at SI 1 -> "CB1#" (parity 0 on 0x42, 1 on 0x31 when enabled)
    si = 2'd1;
    exp_msg(8'h43, 8'h42, 8'h31, 8'h23);
    color = 2'b10;
    step(4);
    chk("t6_led_b", leds, 3'b001);
    wait_drain("t6_drain", 500);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
